qmax_update_ctrl: RTL and testbench

Read-modify-write controller and initiator side of the Q-max table BRAM port: it accepts Q-value update requests `(state, q)`, reads the stored Q-max for that state, and writes back `q` only if it strictly exceeds the stored value. It sits between the Q-value compute pipeline and the `qmaxtable` instance. It sustains one update per cycle, including back-to-back updates to the same state, by forwarding around the table's one-cycle read latency.

---
 rtl/qmax_pkg.sv | 19 +
 rtl/qmax_update_ctrl_if.sv | 36 +++
 rtl/qmaxtable.sv | 27 ++
 rtl/qmax_update_ctrl.sv | 152 +++++++++++++++
 tb/tb_qmax_update_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/qmax_pkg.sv
// qmax_pkg: shared defaults, controller state encoding and update request payload
// for the Q-max table read-modify-write controller.
package qmax_pkg;

   localparam int unsigned QMAX_ADDR_WIDTH = 8;
   localparam int unsigned QMAX_DATA_WIDTH = 8;
   localparam int unsigned QMAX_DEPTH      = 256;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } ctrl_state_e;

   typedef struct packed {
      logic [QMAX_ADDR_WIDTH-1:0] state;
      logic [QMAX_DATA_WIDTH-1:0] q;
   } upd_req_t;

endpackage

// File: rtl/qmax_update_ctrl_if.sv
// qmax_update_ctrl_if: update request, table port and completion signals of the
// Q-max controller; master is the controller side, slave the surrounding logic.
interface qmax_update_ctrl_if
   import qmax_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = QMAX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = QMAX_DATA_WIDTH
) ();

   logic                  i_upd_valid;
   logic                  o_upd_ready;
   logic [ADDR_WIDTH-1:0] i_upd_state;
   logic [DATA_WIDTH-1:0] i_upd_q;
   logic [ADDR_WIDTH-1:0] o_tbl_addr_r;
   logic [DATA_WIDTH-1:0] i_tbl_data;
   logic [ADDR_WIDTH-1:0] o_tbl_addr_w;
   logic [DATA_WIDTH-1:0] o_tbl_data;
   logic                  o_tbl_write_en;
   logic                  o_done_valid;
   logic [ADDR_WIDTH-1:0] o_done_state;
   logic [DATA_WIDTH-1:0] o_done_qmax;
   logic                  o_done_changed;

   modport master (
      input  i_upd_valid, i_upd_state, i_upd_q, i_tbl_data,
      output o_upd_ready, o_tbl_addr_r, o_tbl_addr_w, o_tbl_data, o_tbl_write_en,
      output o_done_valid, o_done_state, o_done_qmax, o_done_changed
   );

   modport slave (
      output i_upd_valid, i_upd_state, i_upd_q, i_tbl_data,
      input  o_upd_ready, o_tbl_addr_r, o_tbl_addr_w, o_tbl_data, o_tbl_write_en,
      input  o_done_valid, o_done_state, o_done_qmax, o_done_changed
   );

endinterface

// File: rtl/qmaxtable.sv
// qmaxtable: simple dual-port Q-max storage, one-cycle registered read that
// returns the pre-write contents when read and write hit the same entry.
module qmaxtable
   import qmax_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = QMAX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = QMAX_DATA_WIDTH,
   parameter int unsigned DEPTH      = QMAX_DEPTH
) (
   input  logic                  i_clk,
   input  logic [ADDR_WIDTH-1:0] i_addr_r,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic [ADDR_WIDTH-1:0] i_addr_w,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_write_en
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_clk) begin : mem_port
      if (i_write_en) begin
         mem[i_addr_w] <= i_data;
      end
      o_data <= mem[i_addr_r];
   end

endmodule

// File: rtl/qmax_update_ctrl.sv
// qmax_update_ctrl: one-update-per-cycle Q-max read-modify-write with last-write
// forwarding. Define QMAX_CLEAR_EN to add a post-reset sweep that zeroes the table.
module qmax_update_ctrl
   import qmax_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = QMAX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = QMAX_DATA_WIDTH,
   parameter int unsigned DEPTH      = QMAX_DEPTH
) (
   input logic                i_clk,
   input logic                i_rst,
   qmax_update_ctrl_if.master bus
);

   if (64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_depth_chk
      $error("qmax_update_ctrl: DEPTH exceeds 2**ADDR_WIDTH");
   end

   logic                  run_c;
   logic                  accept_c;
   logic [DATA_WIDTH-1:0] cur_c;
   logic                  changed_c;
   logic                  upd_we_c;

   logic                  s1_valid;
   logic [ADDR_WIDTH-1:0] s1_state;
   logic [DATA_WIDTH-1:0] s1_q;
   logic                  lw_valid;
   logic [ADDR_WIDTH-1:0] lw_addr;
   logic [DATA_WIDTH-1:0] lw_val;
   logic                  done_valid;
   logic [ADDR_WIDTH-1:0] done_state;
   logic [DATA_WIDTH-1:0] done_qmax;
   logic                  done_changed;

   assign bus.o_upd_ready  = run_c && !i_rst;
   assign accept_c         = bus.i_upd_valid && bus.o_upd_ready;
   assign bus.o_tbl_addr_r = bus.i_upd_state;

   // A read issued on the edge of a write to the same entry returns stale data.
   assign cur_c     = (lw_valid && (lw_addr == s1_state)) ? lw_val : bus.i_tbl_data;
   assign changed_c = s1_q > cur_c;
   assign upd_we_c  = s1_valid && changed_c && !i_rst;

`ifdef QMAX_CLEAR_EN
   localparam logic [0:0]            S_CLEAR   = ST_CLEAR;
   localparam logic [0:0]            S_RUN     = ST_RUN;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic [0:0]            state_q;
   logic [0:0]            state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_d;
   logic                  clr_we_c;

   always_ff @(posedge i_clk) begin : fsm_reg
      if (i_rst) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Sweep writes zero to one entry per cycle, then hands over to RUN.
   always_comb begin : fsm_next
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we_c  = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we_c = !i_rst;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d = S_RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign run_c              = (state_q == S_RUN);
   assign bus.o_tbl_write_en = clr_we_c || upd_we_c;
   assign bus.o_tbl_addr_w   = clr_we_c ? clr_cnt_q : s1_state;
   assign bus.o_tbl_data     = clr_we_c ? '0 : s1_q;
`else
   logic ready_q;

   always_ff @(posedge i_clk) begin : ready_reg
      if (i_rst) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign run_c              = ready_q;
   assign bus.o_tbl_write_en = upd_we_c;
   assign bus.o_tbl_addr_w   = s1_state;
   assign bus.o_tbl_data     = s1_q;
`endif

   always_ff @(posedge i_clk) begin : s1_reg
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_state <= '0;
         s1_q     <= '0;
      end else begin
         s1_valid <= accept_c;
         if (accept_c) begin
            s1_state <= bus.i_upd_state;
            s1_q     <= bus.i_upd_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin : lw_reg
      if (i_rst) begin
         lw_valid <= 1'b0;
         lw_addr  <= '0;
         lw_val   <= '0;
      end else if (upd_we_c) begin
         lw_valid <= 1'b1;
         lw_addr  <= s1_state;
         lw_val   <= s1_q;
      end
   end

   always_ff @(posedge i_clk) begin : done_reg
      if (i_rst) begin
         done_valid   <= 1'b0;
         done_state   <= '0;
         done_qmax    <= '0;
         done_changed <= 1'b0;
      end else begin
         done_valid <= s1_valid;
         if (s1_valid) begin
            done_state   <= s1_state;
            done_qmax    <= changed_c ? s1_q : cur_c;
            done_changed <= changed_c;
         end
      end
   end

   assign bus.o_done_valid   = done_valid;
   assign bus.o_done_state   = done_state;
   assign bus.o_done_qmax    = done_qmax;
   assign bus.o_done_changed = done_changed;

endmodule

// File: tb/tb_qmax_update_ctrl.sv
// tb_qmax_update_ctrl: scoreboard bench for the Q-max controller driving a qmaxtable.
module tb_qmax_update_ctrl;
   import qmax_pkg::*;

   localparam int unsigned AW    = QMAX_ADDR_WIDTH;
   localparam int unsigned DW    = QMAX_DATA_WIDTH;
   localparam int unsigned DEPTH = QMAX_DEPTH;
`ifdef QMAX_CLEAR_EN
   localparam int unsigned READY_LOW = DEPTH;
`else
   localparam int unsigned READY_LOW = 1;
`endif

   typedef struct {
      logic [AW-1:0] s;
      logic [DW-1:0] qmax;
      logic          ch;
      int unsigned   cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int unsigned clr_exp = 0;

   logic [DW-1:0] ref_tbl [DEPTH];
   exp_t          done_q [$];
   upd_req_t      wr_q [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   qmax_update_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   qmax_update_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   qmaxtable #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_tbl (
      .i_clk      (clk),
      .i_addr_r   (bus.o_tbl_addr_r),
      .o_data     (bus.i_tbl_data),
      .i_addr_w   (bus.o_tbl_addr_w),
      .i_data     (bus.o_tbl_data),
      .i_write_en (bus.o_tbl_write_en)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a table of running maxima, updated in acceptance order.
   task automatic model_issue(input logic [AW-1:0] s, input logic [DW-1:0] qv);
      exp_t e;
      e.s    = s;
      e.ch   = qv > ref_tbl[s];
      e.qmax = e.ch ? qv : ref_tbl[s];
      e.cyc  = cyc;
      done_q.push_back(e);
      if (e.ch) begin
         ref_tbl[s] = qv;
         wr_q.push_back('{state: s, q: qv});
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] s, input logic [DW-1:0] qv,
                        input bit model);
      @(posedge clk); #1;
      bus.i_upd_valid = v;
      bus.i_upd_state = s;
      bus.i_upd_q     = qv;
      #1;
      if (v) check("tbl_addr_r", 32'(bus.o_tbl_addr_r), 32'(s));
      if (v && bus.o_upd_ready && model) model_issue(s, qv);
   endtask

   task automatic wait_ready();
      int unsigned n = 0;
      while (!bus.o_upd_ready && n < 4 * DEPTH + 16) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_low_cycles", n, READY_LOW);
   endtask

   task automatic drain();
      int n = 0;
      while ((done_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain_pending", 32'(done_q.size() + wr_q.size()), 0);
   endtask

   task automatic random_run(input int n);
      logic [AW-1:0] last_s = '0;
      logic [AW-1:0] s;
      for (int i = 0; i < n; i++) begin
         s = ($urandom_range(0, 2) == 0) ? last_s : AW'($urandom_range(0, 15));
         drive($urandom_range(0, 3) != 0, s, DW'($urandom_range(0, 255)), 1'b1);
         last_s = s;
      end
      drive(1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: pops the scoreboard for each done pulse and each table write.
   always @(negedge clk) begin : monitor
      exp_t     e;
      upd_req_t w;
      if (bus.o_done_valid) begin
         check("done_expected", 32'(done_q.size() != 0), 1);
         if (done_q.size() != 0) begin
            e = done_q.pop_front();
            check("done_state", 32'(bus.o_done_state), 32'(e.s));
            check("done_qmax", 32'(bus.o_done_qmax), 32'(e.qmax));
            check("done_changed", 32'(bus.o_done_changed), 32'(e.ch));
            check("done_latency", cyc - e.cyc, 2);
         end
      end
      if (bus.o_tbl_write_en) begin
         if (!bus.o_upd_ready) begin
`ifdef QMAX_CLEAR_EN
            check("clr_addr", 32'(bus.o_tbl_addr_w), clr_exp);
            check("clr_data", 32'(bus.o_tbl_data), 0);
            clr_exp++;
`else
            check("write_while_not_ready", 32'(bus.o_tbl_write_en), 0);
`endif
         end else begin
            check("write_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
               w = wr_q.pop_front();
               check("wr_addr", 32'(bus.o_tbl_addr_w), 32'(w.state));
               check("wr_data", 32'(bus.o_tbl_data), 32'(w.q));
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      bus.i_upd_valid = 1'b0;
      bus.i_upd_state = '0;
      bus.i_upd_q     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ref_tbl[i] = '0;
`ifdef QMAX_CLEAR_EN
         u_tbl.mem[i] = DW'($urandom);
`else
         u_tbl.mem[i] = '0;
`endif
      end
`ifdef QMAX_CLEAR_EN
      u_tbl.mem[3] = 8'h55;
`endif

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.o_upd_ready), 0);
      check("rst_done_valid", 32'(bus.o_done_valid), 0);
      check("rst_done_state", 32'(bus.o_done_state), 0);
      check("rst_done_qmax", 32'(bus.o_done_qmax), 0);
      check("rst_done_changed", 32'(bus.o_done_changed), 0);
      check("rst_write_en", 32'(bus.o_tbl_write_en), 0);
      rst = 1'b0;
      wait_ready();
`ifdef QMAX_CLEAR_EN
      check("clear_entry3", 32'(u_tbl.mem[3]), 0);
`endif

      drive(1'b1, 8'd5, 8'h10, 1'b1);
      drive(1'b0, '0, '0, 1'b0);
      drive(1'b0, '0, '0, 1'b0);
      drive(1'b1, 8'd5, 8'h08, 1'b1);
      drive(1'b0, '0, '0, 1'b0);
      drain();
      check("table5", 32'(u_tbl.mem[5]), 32'h10);

      drive(1'b1, 8'd7, 8'h20, 1'b1);
      drive(1'b1, 8'd7, 8'h18, 1'b1);
      drive(1'b1, 8'd7, 8'h30, 1'b1);
      drive(1'b1, 8'd1, 8'h40, 1'b1);
      drive(1'b1, 8'd2, 8'h01, 1'b1);
      drive(1'b1, 8'd1, 8'h3F, 1'b1);
      drive(1'b0, '0, '0, 1'b0);
      drain();
      check("table7", 32'(u_tbl.mem[7]), 32'h30);
      check("table1", 32'(u_tbl.mem[1]), 32'h40);
      check("table2", 32'(u_tbl.mem[2]), 32'h01);

      random_run(400);
      drain();

      // Reset while S1 holds an update: it must vanish without write or done.
      drive(1'b1, 8'd9, 8'hFF, 1'b0);
      check("accept_9", 32'(bus.o_upd_ready), 1);
      @(posedge clk); #1;
      rst             = 1'b1;
      bus.i_upd_valid = 1'b0;
      clr_exp         = 0;
      #1;
      check("rst_cycle_ready", 32'(bus.o_upd_ready), 0);
      check("rst_cycle_write_en", 32'(bus.o_tbl_write_en), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
`ifdef QMAX_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) ref_tbl[i] = '0;
`endif
      wait_ready();

      drive(1'b1, 8'd9, 8'h01, 1'b1);
      random_run(200);
      drain();
      repeat (3) @(posedge clk);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("table[%0d]", i), 32'(u_tbl.mem[i]), 32'(ref_tbl[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
